fp_vec_max_reduce: RTL
======================

# fp_vec_max_reduce

Streaming IEEE-754 single-precision max/min reduction engine with argmax/argmin index, for PNM near-memory pooling and softmax pre-scaling. Accepts LANES floats per beat over a valid/ready stream, reduces an arbitrary-length vector terminated by `in_last`, and returns one result value plus the flat index of the winning element. It is the vector, stateful successor of the single-pair combinational comparator: it adds a min/max mode, correct ±0 and NaN handling, and tie-breaking.

## Interface
- `LANES`, 4: floats per input beat; power of two, 1..16.
- `MAX_BEATS`, 256: beats per vector before overflow is flagged; power of two.
- `IDX_W`, $clog2(MAX_BEATS*LANES): width of the index output (derived; do not override).
- `clk` input 1: single clock, all logic on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `cfg_min` input 1: 0 = max reduction, 1 = min reduction; sampled on the first accepted beat of each vector.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: engine can accept a beat.
- `in_data` input 32*LANES: lane k occupies bits [32k+31:32k].
- `in_last` input 1: final beat of the current vector.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `out_value` output 32: reduced value.
- `out_index` output IDX_W: flat index of the winner, beat*LANES + lane.
- `out_nan` output 1: at least one NaN seen in the vector.
- `out_ovf` output 1: vector exceeded MAX_BEATS beats.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: `in_ready` = 1. An accepted beat latches the mode, loads the accumulator with that beat's lane-tree winner, and sets beat count = 1. The next state is DONE if `in_last`, else ACC.
- ACC: `in_ready` = 1. Each accepted beat compares the lane-tree winner against the accumulator and updates it. `in_last` moves to DONE.
- DONE: `in_ready` = 0, `out_valid` = 1. Outputs stay stable until `out_ready`. The state then returns to IDLE, and all flags and the count clear.
- Comparison order:
  - Total order on non-NaN values by sign-magnitude.
  - +0 and −0 compare equal.
  - A candidate replaces the incumbent only if it is strictly better (greater in max mode, less in min mode).
  - Ties therefore keep the lowest flat index. In the lane tree, the lower lane wins ties.
- NaN (exp = 0xFF, frac ≠ 0):
  - The first NaN in flat order wins unconditionally; later elements, including later NaNs, never displace it.
  - `out_value` is forced to the canonical 0x7FC00000, and `out_nan` = 1.
- Infinities are ordinary extreme values. Denormals compare by raw bits and are not flushed.
- `out_value` returns the winner's original bits, except for NaN. A −0 winner stays 0x80000000.
- Overflow: accepting beat number MAX_BEATS+1 sets a sticky `out_ovf`. The beat is still reduced, but its index computation wraps modulo 2^IDX_W.
- `cfg_min` changes mid-vector are ignored.

## Timing
- Throughput: one beat per cycle in IDLE and ACC.
- Latency: `out_valid` rises on the cycle after the `in_last` beat is accepted.
- The lane-tree comparison is combinational into the accumulator register. The tree is log2(LANES) levels.
- Back-to-back vectors have one bubble: the DONE handshake cycle has `in_ready` = 0, and IDLE is re-entered the cycle after `out_ready`.
- `out_*` are registered, and are held while `out_valid` && !`out_ready`.
- Reset (`rst_n` low at a clock edge), from any state including mid-vector or DONE:
  - next state is IDLE;
  - `in_ready` = 1, `out_valid` = 0;
  - `out_value` = 0, `out_index` = 0, `out_nan` = 0, `out_ovf` = 0;
  - the partial accumulation is discarded.
- No combinational path from `out_ready` to `in_ready`, and none from `in_valid` to any output.

## Test plan
- **Max, LANES=4, 2 beats.** Beat0 = {1.0, −3.0, 2.5, 0.5}, beat1 = {2.5, −inf, 0.0, 2.0} with `in_last`. Expect `out_value` = 0x40200000 (2.5), `out_index` = 2 (tie keeps the earlier element), `out_valid` one cycle after beat1.
- **Min mode.** Same stimulus with `cfg_min` = 1. Expect `out_value` = 0xFF800000 (−inf), `out_index` = 5.
- **Signed zero.** Single beat {0x80000000, 0x00000000, 0xBF800000, 0x80000000}, max mode. Expect `out_value` = 0x80000000, `out_index` = 0.
- **NaN.** Beat0 = {1.0, 0x7F800001, 5.0, 0xFFC00000}, beat1 = {inf, …} with `in_last`. Expect `out_value` = 0x7FC00000, `out_index` = 1, `out_nan` = 1.
- **Backpressure and back-to-back.** Hold `out_ready` = 0 for 5 cycles while driving the next vector. Expect:
  - `in_ready` = 0 and outputs stable throughout;
  - one cycle after `out_ready`, `in_ready` = 1;
  - the second result is independent of the first.
- **Reset and overflow.**
  - Assert `rst_n` = 0 mid-vector: outputs take their reset values next cycle, and a fresh single-beat vector yields the correct result.
  - With MAX_BEATS=4, send 5 beats: expect `out_ovf` = 1.

Source files
------------

// File: rtl/fp_vec_max_reduce.sv
// Streaming IEEE-754 single-precision max/min reduction with argmax/argmin index.
// One beat of LANES floats per cycle; the result is reported after the in_last beat.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first beat of a vector
// ACC   | accumulating beats until in_last
// DONE  | result presented, waiting for out_ready
module fp_vec_max_reduce #(
   parameter int LANES     = 4,
   parameter int MAX_BEATS = 256,
   parameter int IDX_W     = $clog2(MAX_BEATS * LANES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_min,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [32*LANES-1:0]   in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_value,
   output logic [IDX_W-1:0]      out_index,
   output logic                  out_nan,
   output logic                  out_ovf
);

   localparam int LSH = $clog2(LANES);
   localparam int LW  = (LANES > 1) ? LSH : 1;
   localparam int BW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   state_t            state;
   logic              mode_min;
   logic [31:0]       acc_val;
   logic [IDX_W-1:0]  acc_idx;
   logic              acc_ovf;
   logic [BW-1:0]     beat_idx;

   logic              cur_min;
   logic [31:0]       tv [LANES];
   logic [LW-1:0]     tl [LANES];
   logic [31:0]       nxt_val;
   logic [IDX_W-1:0]  nxt_idx;
   logic              nxt_ovf;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Monotonic unsigned key for sign-magnitude order; both zeros map to the same key.
   function automatic logic [31:0] order_key(input logic [31:0] x);
      if (x[30:0] == 31'd0)
         return 32'h8000_0000;
      else if (x[31])
         return ~x;
      else
         return x | 32'h8000_0000;
   endfunction

   // Candidate displaces incumbent only when strictly better; an incumbent NaN is never displaced.
   function automatic logic better(input logic [31:0] c, input logic [31:0] i, input logic mn);
      if (is_nan(i))
         return 1'b0;
      else if (is_nan(c))
         return 1'b1;
      else if (mn)
         return order_key(c) < order_key(i);
      else
         return order_key(c) > order_key(i);
   endfunction

   assign cur_min = (state == S_IDLE) ? cfg_min : mode_min;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         tv[k] = in_data[32*k +: 32];
         tl[k] = LW'(k);
      end
      // Pairwise tree: the lower lane is always the incumbent, so ties keep the lower lane.
      for (int s = 1; s < LANES; s = s * 2) begin
         for (int k = 0; k + s < LANES; k = k + 2 * s) begin
            if (better(tv[k+s], tv[k], cur_min)) begin
               tv[k] = tv[k+s];
               tl[k] = tl[k+s];
            end
         end
      end
      nxt_val = tv[0];
      nxt_idx = (IDX_W'(beat_idx) << LSH) | IDX_W'(tl[0]);
      nxt_ovf = 1'b0;
      if (state == S_ACC) begin
         nxt_ovf = acc_ovf | (beat_idx == '0);
         if (!better(tv[0], acc_val, mode_min)) begin
            nxt_val = acc_val;
            nxt_idx = acc_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_value <= '0;
         out_index <= '0;
         out_nan   <= 1'b0;
         out_ovf   <= 1'b0;
         mode_min  <= 1'b0;
         acc_val   <= '0;
         acc_idx   <= '0;
         acc_ovf   <= 1'b0;
         beat_idx  <= '0;
      end else begin
         case (state)
            S_IDLE, S_ACC: begin
               if (in_valid) begin
                  acc_val  <= nxt_val;
                  acc_idx  <= nxt_idx;
                  acc_ovf  <= nxt_ovf;
                  beat_idx <= beat_idx + 1'b1;
                  if (state == S_IDLE)
                     mode_min <= cfg_min;
                  if (in_last) begin
                     state     <= S_DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_value <= is_nan(nxt_val) ? CANON_NAN : nxt_val;
                     out_index <= nxt_idx;
                     out_nan   <= is_nan(nxt_val);
                     out_ovf   <= nxt_ovf;
                  end else begin
                     state <= S_ACC;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  out_nan   <= 1'b0;
                  out_ovf   <= 1'b0;
                  acc_ovf   <= 1'b0;
                  beat_idx  <= '0;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
